// File: rtl/fcpu_pkg.sv
// rtl/fcpu_pkg.sv - shared core widths and CDB requester index assignment
package fcpu_pkg;
  localparam int RSV_ID_W  = 6;
  localparam int DATA_W    = 32;
  localparam int CDB_W     = RSV_ID_W + DATA_W;

  localparam int CDB_N_REQ = 4;
  localparam int CDB_REQ_ALU = 0;
  localparam int CDB_REQ_FPU = 1;
  localparam int CDB_REQ_BRU = 2;
  localparam int CDB_REQ_LSU = 3;
endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - rotating-priority find-first-set, one-hot grant plus index
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  localparam int SW = IDX_W + 1;

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [SW-1:0]    sum;

  always_comb begin
    // rotate so requester ptr sits at bit 0, then lowest set bit wins
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    any = |req;
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= SW'(N)) sum = sum - SW'(N);
    idx = sum[IDX_W-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
module cdb_arbiter
  import fcpu_pkg::CDB_N_REQ;
#(
  parameter int N_REQ = CDB_N_REQ,
  parameter int CDB_W = fcpu_pkg::CDB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*CDB_W-1:0]   req_data,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     flush,
  output logic [CDB_W-1:0]         cdb,
  output logic                     cdb_valid,
  output logic [$clog2(N_REQ)-1:0] cdb_src,
  output logic [N_REQ*16-1:0]      grant_count
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [CDB_W-1:0] cdb_q, cdb_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;
  logic [15:0]      cnt_q [N_REQ];
  logic [15:0]      cnt_d [N_REQ];

  logic [N_REQ-1:0] gnt;
  logic [SRC_W-1:0] idx;
  logic             any;
  logic             fire;

  rr_priority_pick #(.N(N_REQ), .IDX_W(SRC_W)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    req_ready   = (rst || flush) ? '0 : gnt;
    fire        = any && !flush && !rst;
    ptr_d       = ptr_q;
    cdb_d       = cdb_q;
    cdb_src_d   = cdb_src_q;
    cdb_valid_d = 1'b0;
    cnt_d       = cnt_q;
    if (fire) begin
      cdb_d       = req_data[idx*CDB_W +: CDB_W];
      cdb_valid_d = 1'b1;
      cdb_src_d   = idx;
      ptr_d       = (idx == SRC_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      if (cnt_q[idx] != 16'hFFFF) cnt_d[idx] = cnt_q[idx] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < N_REQ; i++) grant_count[i*16 +: 16] = cnt_q[i];
  end

  assign cdb       = cdb_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter against a round-robin reference model
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N = 4;
  localparam int W = CDB_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic             flush;
  logic [W-1:0]     cdb;
  logic             cdb_valid;
  logic [1:0]       cdb_src;
  logic [N*16-1:0]  grant_count;

  cdb_arbiter #(.N_REQ(N), .CDB_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .flush       (flush),
    .cdb         (cdb),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .grant_count (grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           v;
    logic [W-1:0] d;
    int           src;
  } exp_t;

  exp_t         q[$];
  bit           mon_en = 1'b0;
  int           n_pass = 0;
  int           n_total = 0;
  int           ptr_m;
  int           cnt_m [N];
  logic [W-1:0] data_arr [N];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = data_arr[i];
  endtask

  task automatic reset_model();
    ptr_m = 0;
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
  endtask

  // One arbitration cycle: drive, check ready, predict the broadcast for the next edge.
  task automatic step(input logic [N-1:0] v, input logic f, output int win);
    exp_t e;
    logic [N-1:0] er;
    @(posedge clk);
    #2;
    req_valid = v;
    flush     = f;
    drive_data();
    #1;
    win = -1;
    if (!f) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr_m + k) % N;
        if (v[c]) begin
          win = c;
          break;
        end
      end
    end
    er = '0;
    if (win >= 0) er[win] = 1'b1;
    chk(req_ready == er, "req_ready", 64'(req_ready), 64'(er));
    e.v   = (win >= 0);
    e.d   = (win >= 0) ? data_arr[win] : '0;
    e.src = (win >= 0) ? win : 0;
    q.push_back(e);
    if (win >= 0) begin
      ptr_m = (win + 1) % N;
      if (cnt_m[win] < 65535) cnt_m[win]++;
    end
  endtask

  task automatic check_counts();
    for (int i = 0; i < N; i++)
      chk(grant_count[i*16 +: 16] == 16'(cnt_m[i]), $sformatf("grant_count[%0d]", i),
          64'(grant_count[i*16 +: 16]), 64'(cnt_m[i]));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        chk(cdb_valid == e.v, "cdb_valid", 64'(cdb_valid), 64'(e.v));
        if (e.v) begin
          chk(cdb == e.d, "cdb", 64'(cdb), 64'(e.d));
          chk(cdb_src == 2'(e.src), "cdb_src", 64'(cdb_src), 64'(e.src));
        end
      end
    end
  end

  initial begin
    int w;
    logic [N-1:0] v2;
    logic [N-1:0] pend;
    logic f;

    rst       = 1'b1;
    req_valid = '1;
    flush     = 1'b0;
    req_data  = '0;
    for (int i = 0; i < N; i++) data_arr[i] = '0;
    reset_model();
    #3;
    chk(req_ready == '0, "reset req_ready", 64'(req_ready), 64'd0);
    chk(cdb_valid == 1'b0, "reset cdb_valid", 64'(cdb_valid), 64'd0);
    chk(cdb == '0, "reset cdb", 64'(cdb), 64'd0);
    chk(cdb_src == '0, "reset cdb_src", 64'(cdb_src), 64'd0);
    chk(grant_count == '0, "reset grant_count", grant_count, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst       = 1'b0;
    req_valid = '0;
    mon_en    = 1'b1;

    repeat (5) step(4'b0000, 1'b0, w);
    chk(cdb == '0, "idle cdb", 64'(cdb), 64'd0);

    for (int i = 0; i < N; i++) data_arr[i] = {RSV_ID_W'(i), DATA_W'(32'hA0 + i)};
    repeat (8) step(4'b1111, 1'b0, w);
    step(4'b0000, 1'b0, w);
    check_counts();

    repeat (3) step(4'b0100, 1'b0, w);
    step(4'b1010, 1'b0, w);
    v2 = 4'b1010;
    if (w >= 0) v2[w] = 1'b0;
    step(v2, 1'b0, w);

    repeat (2) step(4'b1111, 1'b0, w);
    step(4'b1111, 1'b1, w);
    repeat (3) step(4'b1111, 1'b0, w);

    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]     = 1'b1;
          data_arr[i] = W'({$urandom(), $urandom()});
        end
      end
      f = ($urandom_range(0, 9) == 0);
      step(pend, f, w);
      if (w >= 0) pend[w] = 1'b0;
    end
    step(4'b0000, 1'b0, w);
    check_counts();

    step(4'b1111, 1'b0, w);
    @(posedge clk);
    #5;
    rst    = 1'b1;
    mon_en = 1'b0;
    q.delete();
    reset_model();
    #1;
    chk(cdb_valid == 1'b0, "async rst cdb_valid", 64'(cdb_valid), 64'd0);
    chk(cdb == '0, "async rst cdb", 64'(cdb), 64'd0);
    chk(cdb_src == '0, "async rst cdb_src", 64'(cdb_src), 64'd0);
    chk(grant_count == '0, "async rst grant_count", grant_count, 64'd0);
    chk(req_ready == '0, "async rst req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #2;
    req_valid = '0;
    rst       = 1'b0;
    mon_en    = 1'b1;
    for (int i = 0; i < N; i++) data_arr[i] = {RSV_ID_W'(8 + i), DATA_W'(32'h5000 + i)};
    step(4'b1010, 1'b0, w);
    v2 = 4'b1010;
    if (w >= 0) v2[w] = 1'b0;
    step(v2, 1'b0, w);

    data_arr[0] = {RSV_ID_W'(1), DATA_W'(32'hC0DE)};
    repeat (65540) step(4'b0001, 1'b0, w);
    step(4'b0000, 1'b0, w);
    check_counts();

    repeat (2) @(posedge clk);
    #2;
    chk(q.size() == 0, "scoreboard drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) between the execution units: ALU, FPU, branch unit and load/store. Each unit offers a tagged result `{rsv_id, data}` on a valid/ready handshake. The arbiter grants at most one unit per cycle and drives the winner onto a registered CDB broadcast. The broadcast feeds every reservation station and the ROB. A flush input discards results in flight when a branch miss is committed.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesting units; legal range 2..8.
- `CDB_W`, default `fcpu_pkg::CDB_W`: width of one result (`RSV_ID_W + DATA_W`).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset; **asynchronous, active-high**.
- `req_data`  in  `N_REQ*CDB_W`  packed results; requester i occupies bits `[i*CDB_W +: CDB_W]`.
- `req_valid`  in  `N_REQ`  per-requester valid.
- `req_ready`  out  `N_REQ`  per-requester grant; one-hot or zero.
- `flush`  in  1  branch miss (driven from the branch unit's `pred_miss`); kills the current grant and the broadcast.
- `cdb`  out  `CDB_W`  broadcast result.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_src`  out  `$clog2(N_REQ)`  index of the requester whose result is on `cdb`.
- `grant_count`  out  `N_REQ*16`  saturating per-requester grant counters (debug/perf).

## Operation
- Pointer `ptr` holds the highest-priority requester index.
- Candidates are scanned in the order `ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1`. The first one with `req_valid` high wins, index `g`.
- `req_ready[g]=1` is driven combinationally. All other ready bits are 0. With no valid requester, `req_ready=0`.
- Handshake completes when `req_valid[g] & req_ready[g]`.
- On completion at an edge:
  - `cdb <= req_data[g]`, `cdb_valid <= 1`, `cdb_src <= g`.
  - `ptr <= (g+1) mod N_REQ`; wrap from `N_REQ-1` goes to 0.
  - `grant_count[g]` increments and saturates at 16'hFFFF.
- No completion: `cdb_valid <= 0`. `cdb`, `cdb_src` and `ptr` hold their values.
- `cdb` has no back-pressure. The output register accepts every cycle, so throughput is one result per cycle.
- Flush, in the cycle `flush=1`:
  - `req_ready` is forced to 0, so no handshake completes.
  - At the edge, `cdb_valid <= 0`.
  - `ptr` and the counters are unchanged.
  - Requesters keep their data, or drop it under their own flush logic.
  - A result registered in the cycle before `flush` has already been broadcast. Invalidating it is the ROB's job.
- Requesters must not make `req_valid` depend on `req_ready`. Once raised, valid and data are held until granted or flushed.

## Timing
- Reset values: `cdb=0`, `cdb_valid=0`, `cdb_src=0`, `ptr=0`, all `grant_count=0`. `req_ready` is 0 while `rst` is high.
- Latency: a handshake in cycle N gives `cdb_valid=1` carrying that result in cycle N+1.
- Combinational path: `req_valid`/`ptr`/`flush` → `req_ready`. There is no combinational path from inputs to `cdb`/`cdb_valid`.
- Single requester continuously valid: granted every cycle, `cdb_valid` held at 1.
- Requester deasserting valid while another is valid: the scan skips it in the same cycle.
- Reset asserted mid-stream: all outputs go to their reset values immediately, without waiting for a clock edge. The first grant after reset release goes to the lowest valid index.
- `flush` and `rst` together: `rst` dominates.

## Structure
- `CDB_W`, `RSV_ID_W` and `DATA_W` come from `fcpu_pkg`. No new package types are required.
- Add the constant `CDB_N_REQ = 4` and the requester index assignment to `fcpu_pkg`: 0 = ALU, 1 = FPU, 2 = BRU, 3 = LSU.
- Sub-module `rr_priority_pick`: a combinational rotate / find-first-set / rotate-back taking `N_REQ` request bits and `ptr`. It outputs a one-hot grant and an index. It is reusable by the reservation-station issue logic.

## Test plan
- Reset, then `req_valid=4'b0000` for 5 cycles → `req_ready=0`, `cdb_valid=0`, `cdb=0`.
- `req_valid=4'b1111` for 8 cycles, data = `{tag=i, data=32'hA0+i}` → `cdb_src` sequence is 0,1,2,3,0,1,2,3 starting one cycle after the first grant; `cdb_valid` stays 1; each `grant_count` is 2.
- Only requester 2 valid for 3 cycles, then requesters 1 and 3 valid with `ptr=3` → 2,2,2 granted, then 3, then 1.
- All four valid, `flush=1` for one cycle mid-stream → `req_ready=0` in that cycle, `cdb_valid=0` the next cycle, and arbitration resumes at the unchanged `ptr`.
- Assert `rst` asynchronously between edges while `cdb_valid=1` → `cdb_valid` falls without waiting for a clock edge. After release with `req_valid=4'b1010`, requester 1 is granted first.
- Drive requester 0 valid continuously for 70000 cycles → `grant_count[0]` saturates at 16'hFFFF.
